// File: rtl/upe_abs_pipe.sv
// Two-stage pipelined absolute-value unit: one full-width lane or two packed half-width lanes,
// valid/ready handshake, optional saturation of the most-negative value, overflow event counter.
module upe_abs_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SAT   = 0,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sign,
    output logic [1:0]       out_ovf,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             ovf_clear
);
    localparam int unsigned HALF = WIDTH / 2;
    localparam logic [WIDTH-1:0] OneFull = WIDTH'(1);
    localparam logic [HALF-1:0]  OneHalf = HALF'(1);
    localparam logic [WIDTH-1:0] MaxFull = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [HALF-1:0]  MaxHalf = {1'b0, {(HALF - 1){1'b1}}};

    logic             v1_q, v2_q;
    logic [WIDTH-1:0] s1_data_q;
    logic             s1_mode_q;
    logic [WIDTH-1:0] res_q, res_d;
    logic [1:0]       sign_q, sign_d;
    logic [1:0]       ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_load, s2_load;

    assign s2_load   = ~v2_q | out_ready;
    assign s1_load   = ~v1_q | s2_load;
    assign in_ready  = s1_load;
    assign out_valid = v2_q;
    assign out_data  = res_q;
    assign out_sign  = sign_q;
    assign out_ovf   = ovf_q;
    assign ovf_count = cnt_q;

    // Per-lane arithmetic on the S1 operand
    logic [WIDTH-1:0] x, full_abs;
    logic [HALF-1:0]  lo, hi, lo_abs, hi_abs;
    logic             full_sign, lo_sign, hi_sign, full_mn, lo_mn, hi_mn;

    always_comb begin
        x         = s1_data_q;
        lo        = x[HALF-1:0];
        hi        = x[WIDTH-1:HALF];
        full_sign = x[WIDTH-1];
        lo_sign   = lo[HALF-1];
        hi_sign   = hi[HALF-1];
        full_mn   = full_sign & ~|x[WIDTH-2:0];
        lo_mn     = lo_sign & ~|lo[HALF-2:0];
        hi_mn     = hi_sign & ~|hi[HALF-2:0];

        full_abs = full_sign ? (~x + OneFull) : x;
        lo_abs   = lo_sign ? (~lo + OneHalf) : lo;
        hi_abs   = hi_sign ? (~hi + OneHalf) : hi;
        if (SAT != 0) begin
            if (full_mn) full_abs = MaxFull;
            if (lo_mn)   lo_abs   = MaxHalf;
            if (hi_mn)   hi_abs   = MaxHalf;
        end

        if (s1_mode_q) begin
            res_d  = {hi_abs, lo_abs};
            sign_d = {hi_sign, lo_sign};
            ovf_d  = {hi_mn, lo_mn};
        end else begin
            res_d  = full_abs;
            sign_d = {1'b0, full_sign};
            ovf_d  = {1'b0, full_mn};
        end
    end

    // Saturating counter; clear wins over a same-cycle increment
    logic [1:0]     ovf_inc;
    logic [CNT_W:0] cnt_sum;

    always_comb begin
        ovf_inc = {1'b0, ovf_q[0]} + {1'b0, ovf_q[1]};
        cnt_sum = {1'b0, cnt_q} + (CNT_W + 1)'(ovf_inc);
        cnt_d   = cnt_q;
        if (ovf_clear) begin
            cnt_d = '0;
        end else if (v2_q && out_ready) begin
            cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q      <= 1'b0;
            s1_data_q <= '0;
            s1_mode_q <= 1'b0;
        end else if (s1_load) begin
            v1_q <= in_valid;
            if (in_valid) begin
                s1_data_q <= in_data;
                s1_mode_q <= in_mode;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v2_q   <= 1'b0;
            res_q  <= '0;
            sign_q <= '0;
            ovf_q  <= '0;
        end else if (s2_load) begin
            v2_q <= v1_q;
            if (v1_q) begin
                res_q  <= res_d;
                sign_q <= sign_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule
